// File: rtl/rat_checkpoint_ctrl_pkg.sv
// Shared types and default sizing for the rename-map checkpoint controller.
package rat_checkpoint_ctrl_pkg;

  localparam int unsigned DEF_ARCH_REGS = 64;
  localparam int unsigned DEF_PHYS_REGS = 128;
  localparam int unsigned DEF_NUM_CKPT  = 4;
  localparam int unsigned PHYS_W        = $clog2(DEF_PHYS_REGS);
  localparam int unsigned DEF_TAG_W     = $clog2(DEF_NUM_CKPT);

  typedef struct packed {
    logic [PHYS_W-1:0] phys;
    logic              valid;
  } map_entry_t;

  typedef logic [DEF_TAG_W-1:0] ckpt_tag_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } ckpt_state_e;

endpackage

// File: rtl/rat_checkpoint_ctrl.sv
// Branch checkpoint manager: allocates map snapshots per branch, frees them in order,
// and sequences a one-cycle restore/squash on a mispredict.
module rat_checkpoint_ctrl
  import rat_checkpoint_ctrl_pkg::*;
#(
  parameter  int unsigned ARCH_REGS = DEF_ARCH_REGS,
  parameter  int unsigned NUM_CKPT  = DEF_NUM_CKPT,
  localparam int unsigned TAG_W     = $clog2(NUM_CKPT),
  localparam int unsigned PTR_W     = TAG_W + 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ckpt_req_i,
  input  map_entry_t [ARCH_REGS-1:0]    ckpt_map_i,
  output logic                          ckpt_gnt_o,
  output logic [TAG_W-1:0]              ckpt_tag_o,
  input  logic                          resolve_valid_i,
  input  logic [TAG_W-1:0]              resolve_tag_i,
  input  logic                          resolve_mispred_i,
  output logic                          restore_valid_o,
  output map_entry_t [ARCH_REGS-1:0]    restore_map_o,
  output logic                          squash_o,
  output logic [PTR_W-1:0]              free_count_o
);

  ckpt_state_e               state_q, state_d;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d, pos_q;
  logic [NUM_CKPT-1:0]       valid_q, valid_d, resolved_q, resolved_d, keep;
  map_entry_t [ARCH_REGS-1:0] slot_q [NUM_CKPT];

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic [PTR_W-1:0] mis_pos, restore_len;
  logic             mispred_c, accept_mis, accept_res, free_head, alloc;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign mispred_c  = resolve_valid_i && resolve_mispred_i;
  assign accept_mis = (state_q == ST_IDLE) && mispred_c && valid_q[resolve_tag_i];
  assign accept_res = (state_q == ST_IDLE) && resolve_valid_i && !resolve_mispred_i
                      && valid_q[resolve_tag_i];
  assign free_head  = valid_q[head_idx] && resolved_q[head_idx];

  assign free_count_o = PTR_W'(NUM_CKPT) - (tail_q - head_q);
  assign ckpt_gnt_o   = (state_q == ST_IDLE) && (free_count_o != '0) && !mispred_c;
  assign ckpt_tag_o   = tail_idx;
  assign alloc        = ckpt_req_i && ckpt_gnt_o;

  // Full pointer position of the mispredicted tag, keeping the age bit relative to head.
  assign mis_pos     = head_q + PTR_W'(TAG_W'(resolve_tag_i - head_idx));
  assign restore_len = pos_q - head_q;

  assign restore_valid_o = (state_q == ST_RESTORE);
  assign squash_o        = (state_q == ST_RESTORE);
  assign restore_map_o   = slot_q[pos_q[TAG_W-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_mis) state_d = ST_RESTORE;
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Slots older than the mispredicted tag survive the restore; everything else is dropped.
  always_comb begin
    keep = '0;
    for (int unsigned i = 0; i < NUM_CKPT; i++)
      keep[i] = PTR_W'(TAG_W'(TAG_W'(i) - head_idx)) < restore_len;
  end

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (accept_res) resolved_d[resolve_tag_i] = 1'b1;
    if (free_head) begin
      valid_d[head_idx]    = 1'b0;
      resolved_d[head_idx] = 1'b0;
      head_d               = head_q + PTR_W'(1);
    end
    if (alloc) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + PTR_W'(1);
    end
    // Tag slot stays live through RESTORE so restore_map_o can read it.
    if (accept_mis) tail_d = mis_pos + PTR_W'(1);
    if (state_q == ST_RESTORE) begin
      tail_d     = pos_q;
      valid_d    = valid_d & keep;
      resolved_d = resolved_d & keep;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      pos_q      <= '0;
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      if (accept_mis) pos_q <= mis_pos;
    end
  end

  // Snapshot storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (alloc) slot_q[tail_idx] <= ckpt_map_i;
  end

endmodule
